// File: rtl/stack_alu_sequencer.sv
// Operand-stack sequencer: retires PUSH/POP/DUP in one cycle and runs binary ops
// through the external combinational ALU over a LOAD/EXEC/WB sequence.
module stack_alu_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [1:0]     instr_kind,
  input  logic [2:0]     instr_op,
  input  logic [7:0]     instr_imm,
  output logic [7:0]     alu_a,
  output logic [7:0]     alu_b,
  output logic [2:0]     alu_op,
  input  logic [7:0]     alu_out,
  output logic [7:0]     top,
  output logic [SPW-1:0] depth,
  output logic           done,
  output logic           err_overflow,
  output logic           err_underflow,
  input  logic           err_clr
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] K_PUSH = 2'd0;
  localparam logic [1:0] K_POP  = 2'd1;
  localparam logic [1:0] K_DUP  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_WB} state_e;

  state_e         state_q, state_d;
  logic [7:0]     stack_q [DEPTH];
  logic [SPW-1:0] depth_q, depth_d;
  logic [2:0]     op_q, op_d;
  logic [7:0]     alu_a_q, alu_a_d;
  logic [7:0]     alu_b_q, alu_b_d;
  logic [2:0]     alu_op_q, alu_op_d;
  logic [7:0]     result_q, result_d;
  logic           ready_q;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           set_ovf, set_unf;
  logic           we;
  logic [AW-1:0]  waddr;
  logic [7:0]     wdata;
  logic [AW-1:0]  idx_top, idx_sec;
  logic           empty, full, has_two, accept;

  assign idx_top = AW'(depth_q - SPW'(1));
  assign idx_sec = AW'(depth_q - SPW'(2));
  assign empty   = (depth_q == '0);
  assign full    = (depth_q == SPW'(DEPTH));
  assign has_two = (depth_q >= SPW'(2));
  assign accept  = instr_valid && ready_q;

  // Next-state, stack write port and fault detection
  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    op_d     = op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    done_d   = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    we       = 1'b0;
    waddr    = AW'(depth_q);
    wdata    = instr_imm;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          done_d = 1'b1;
          unique case (instr_kind)
            K_PUSH: begin
              if (full) begin
                set_ovf = 1'b1;
              end else begin
                we      = 1'b1;
                depth_d = depth_q + SPW'(1);
              end
            end
            K_POP: begin
              if (empty) set_unf = 1'b1;
              else       depth_d = depth_q - SPW'(1);
            end
            K_DUP: begin
              if (empty) begin
                set_unf = 1'b1;
              end else if (full) begin
                set_ovf = 1'b1;
              end else begin
                we      = 1'b1;
                wdata   = stack_q[idx_top];
                depth_d = depth_q + SPW'(1);
              end
            end
            default: begin
              if (!has_two) begin
                set_unf = 1'b1;
              end else begin
                done_d  = 1'b0;
                op_d    = instr_op;
                state_d = S_LOAD;
              end
            end
          endcase
        end
      end
      S_LOAD: begin
        alu_a_d  = stack_q[idx_sec];
        alu_b_d  = stack_q[idx_top];
        alu_op_d = op_q;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_out;
        state_d  = S_WB;
      end
      S_WB: begin
        we      = 1'b1;
        waddr   = idx_sec;
        wdata   = result_q;
        depth_d = depth_q - SPW'(1);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A fault on the same edge as err_clr leaves the flag set
    ovf_d = set_ovf | (ovf_q & ~err_clr);
    unf_d = set_unf | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      depth_q  <= '0;
      op_q     <= 3'd0;
      alu_a_q  <= 8'h00;
      alu_b_q  <= 8'h00;
      alu_op_q <= 3'd0;
      result_q <= 8'h00;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      op_q     <= op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      ready_q  <= (state_d == S_IDLE);
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Stack storage has no reset; reset only suppresses a pending write-back
  always_ff @(posedge clk) begin
    if (!reset && we) stack_q[waddr] <= wdata;
  end

  assign top           = empty ? 8'h00 : stack_q[idx_top];
  assign depth         = depth_q;
  assign instr_ready   = ready_q;
  assign done          = done_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: directed scenarios plus randomized instructions
// checked against a queue-based stack model.
module tb_stack_alu_sequencer;
  localparam int DEPTH = 8;
  localparam int SPW   = $clog2(DEPTH + 1);

  localparam logic [1:0] K_PUSH = 2'd0;
  localparam logic [1:0] K_POP  = 2'd1;
  localparam logic [1:0] K_ALU  = 2'd2;
  localparam logic [1:0] K_DUP  = 2'd3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_SRA = 3'd4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           instr_valid = 1'b0;
  logic           instr_ready;
  logic [1:0]     instr_kind = 2'd0;
  logic [2:0]     instr_op = 3'd0;
  logic [7:0]     instr_imm = 8'h00;
  logic [7:0]     alu_a, alu_b;
  logic [2:0]     alu_op;
  logic [7:0]     alu_out;
  logic [7:0]     top;
  logic [SPW-1:0] depth;
  logic           done;
  logic           err_overflow, err_underflow;
  logic           err_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mstack[$];
  logic       m_ovf, m_unf;

  always #5 clk = ~clk;

  stack_alu_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_kind(instr_kind), .instr_op(instr_op), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .top(top), .depth(depth), .done(done),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_clr(err_clr)
  );

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a << b;
      3'd3:    return a >> b;
      3'd4:    return 8'($signed(a) >>> b);
      3'd5:    return a & b;
      3'd6:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // External ALU stand-in
  always_comb alu_out = alu_ref(alu_op, alu_a, alu_b);

  function automatic logic [7:0] mtop();
    return (mstack.size() == 0) ? 8'h00 : mstack[$];
  endfunction

  task automatic model_step(input logic [1:0] k, input logic [2:0] o, input logic [7:0] im,
                            input logic clr, output int exp_lat,
                            output logic [7:0] ea, output logic [7:0] eb);
    logic fo, fu;
    logic [7:0] x, y;
    fo = 1'b0; fu = 1'b0; exp_lat = 0; ea = 8'h00; eb = 8'h00;
    case (k)
      K_PUSH: if (mstack.size() >= DEPTH) fo = 1'b1; else mstack.push_back(im);
      K_POP:  if (mstack.size() == 0) fu = 1'b1; else void'(mstack.pop_back());
      K_DUP: begin
        if (mstack.size() == 0)          fu = 1'b1;
        else if (mstack.size() >= DEPTH) fo = 1'b1;
        else                             mstack.push_back(mstack[$]);
      end
      default: begin
        if (mstack.size() < 2) begin
          fu = 1'b1;
        end else begin
          y = mstack.pop_back();
          x = mstack.pop_back();
          ea = x; eb = y;
          mstack.push_back(alu_ref(o, x, y));
          exp_lat = 3;
        end
      end
    endcase
    m_ovf = fo | (m_ovf & ~clr);
    m_unf = fu | (m_unf & ~clr);
  endtask

  // Presents one instruction, returns ready-at-accept, accept-to-done latency
  // (-1 on timeout) and the ALU operand registers seen one cycle after LOAD.
  task automatic drive_instr(input logic [1:0] k, input logic [2:0] o, input logic [7:0] im,
                             input logic clr, output logic rdy, output int lat,
                             output logic [7:0] xa, output logic [7:0] xb, output logic [2:0] xop);
    @(negedge clk);
    instr_kind = k; instr_op = o; instr_imm = im; err_clr = clr; instr_valid = 1'b1;
    rdy = instr_ready;
    @(posedge clk); #1;
    instr_valid = 1'b0; err_clr = 1'b0;
    lat = 0; xa = alu_a; xb = alu_b; xop = alu_op;
    while (done !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin xa = alu_a; xb = alu_b; xop = alu_op; end
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; instr_valid = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mstack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (depth !== '0) begin n_errors++; $display("FAIL reset_depth: got %0d expected 0", depth); end
    n_checks++; if (top !== 8'h00) begin n_errors++; $display("FAIL reset_top: got %0h expected 0", top); end
    n_checks++; if (instr_ready !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL reset_hs: got ready=%b done=%b expected ready=1 done=0", instr_ready, done); end
    n_checks++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b%b expected 00", err_overflow, err_underflow); end
    n_checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 3'd0) begin n_errors++; $display("FAIL reset_alu: got a=%0h b=%0h op=%0d expected 0 0 0", alu_a, alu_b, alu_op); end
    reset = 1'b0;
    mstack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_alu_directed();
    logic [7:0] ta [4] = '{8'h05, 8'h80, 8'h80, 8'hFF};
    logic [7:0] tb [4] = '{8'h03, 8'h01, 8'h01, 8'h02};
    logic [2:0] to [4] = '{OP_SUB, OP_SRA, OP_SHR, OP_ADD};
    logic [7:0] tr [4] = '{8'h02, 8'hC0, 8'h40, 8'h01};
    logic rdy; int lat, el; logic [7:0] xa, xb, ea, eb; logic [2:0] xop;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_instr(K_PUSH, 3'd0, ta[i], 1'b0, rdy, lat, xa, xb, xop);
      model_step(K_PUSH, 3'd0, ta[i], 1'b0, el, ea, eb);
      drive_instr(K_PUSH, 3'd0, tb[i], 1'b0, rdy, lat, xa, xb, xop);
      model_step(K_PUSH, 3'd0, tb[i], 1'b0, el, ea, eb);
      drive_instr(K_ALU, to[i], 8'h00, 1'b0, rdy, lat, xa, xb, xop);
      model_step(K_ALU, to[i], 8'h00, 1'b0, el, ea, eb);
      n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL dir_latency[%0d]: got %0d expected 3", i, lat); end
      n_checks++; if (xa !== ta[i] || xb !== tb[i] || xop !== to[i]) begin n_errors++; $display("FAIL dir_exec_ops[%0d]: got a=%0h b=%0h op=%0d expected %0h %0h %0d", i, xa, xb, xop, ta[i], tb[i], to[i]); end
      n_checks++; if (top !== tr[i]) begin n_errors++; $display("FAIL dir_top[%0d]: got %0h expected %0h", i, top, tr[i]); end
      n_checks++; if (depth !== SPW'(i + 1)) begin n_errors++; $display("FAIL dir_depth[%0d]: got %0d expected %0d", i, depth, i + 1); end
    end
  endtask

  task automatic test_overflow();
    logic rdy; int lat, el; logic [7:0] xa, xb, ea, eb; logic [2:0] xop;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_instr(K_PUSH, 3'd0, 8'h11, 1'b0, rdy, lat, xa, xb, xop);
      model_step(K_PUSH, 3'd0, 8'h11, 1'b0, el, ea, eb);
    end
    n_checks++; if (err_overflow !== 1'b0) begin n_errors++; $display("FAIL fill_no_ovf: got %b expected 0", err_overflow); end
    drive_instr(K_PUSH, 3'd0, 8'h22, 1'b0, rdy, lat, xa, xb, xop);
    n_checks++; if (lat !== 0) begin n_errors++; $display("FAIL ovf_push_done: got latency %0d expected 0", lat); end
    n_checks++; if (err_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_push_flag: got %b expected 1", err_overflow); end
    n_checks++; if (depth !== SPW'(DEPTH) || top !== 8'h11) begin n_errors++; $display("FAIL ovf_push_state: got depth=%0d top=%0h expected %0d 11", depth, top, DEPTH); end
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    n_checks++; if (err_overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b expected 0", err_overflow); end
    drive_instr(K_DUP, 3'd0, 8'h00, 1'b0, rdy, lat, xa, xb, xop);
    n_checks++; if (lat !== 0 || err_overflow !== 1'b1 || err_underflow !== 1'b0) begin n_errors++; $display("FAIL ovf_dup: got lat=%0d ovf=%b unf=%b expected 0 1 0", lat, err_overflow, err_underflow); end
    n_checks++; if (depth !== SPW'(DEPTH) || top !== 8'h11) begin n_errors++; $display("FAIL ovf_dup_state: got depth=%0d top=%0h expected %0d 11", depth, top, DEPTH); end
  endtask

  task automatic test_underflow();
    logic rdy; int lat; logic [7:0] xa, xb; logic [2:0] xop;
    do_reset();
    drive_instr(K_POP, 3'd0, 8'h00, 1'b0, rdy, lat, xa, xb, xop);
    n_checks++; if (lat !== 0 || err_underflow !== 1'b1 || depth !== '0) begin n_errors++; $display("FAIL unf_pop: got lat=%0d unf=%b depth=%0d expected 0 1 0", lat, err_underflow, depth); end
    drive_instr(K_PUSH, 3'd0, 8'h07, 1'b0, rdy, lat, xa, xb, xop);
    drive_instr(K_ALU, OP_ADD, 8'h00, 1'b0, rdy, lat, xa, xb, xop);
    n_checks++; if (lat !== 0) begin n_errors++; $display("FAIL unf_alu_done: got latency %0d expected 0", lat); end
    n_checks++; if (err_underflow !== 1'b1 || depth !== SPW'(1) || top !== 8'h07) begin n_errors++; $display("FAIL unf_alu_state: got unf=%b depth=%0d top=%0h expected 1 1 07", err_underflow, depth, top); end
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    n_checks++; if (err_underflow !== 1'b0 || err_overflow !== 1'b0) begin n_errors++; $display("FAIL unf_clear: got %b%b expected 00", err_overflow, err_underflow); end
    drive_instr(K_ALU, OP_ADD, 8'h00, 1'b1, rdy, lat, xa, xb, xop);
    n_checks++; if (err_underflow !== 1'b1) begin n_errors++; $display("FAIL set_beats_clr: got %b expected 1", err_underflow); end
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    mstack.delete(); mstack.push_back(8'h07); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic rdy; int lat, el, low, dn; logic [7:0] xa, xb, ea, eb, x0, x1, exp_sum; logic [2:0] xop;
    do_reset();
    x0 = 8'($urandom); x1 = 8'($urandom);
    drive_instr(K_PUSH, 3'd0, 8'h21, 1'b0, rdy, lat, xa, xb, xop);
    model_step(K_PUSH, 3'd0, 8'h21, 1'b0, el, ea, eb);
    drive_instr(K_PUSH, 3'd0, 8'h34, 1'b0, rdy, lat, xa, xb, xop);
    model_step(K_PUSH, 3'd0, 8'h34, 1'b0, el, ea, eb);
    @(negedge clk);
    instr_kind = K_ALU; instr_op = OP_ADD; instr_valid = 1'b1;
    @(posedge clk); #1;
    model_step(K_ALU, OP_ADD, 8'h00, 1'b0, el, ea, eb);
    exp_sum = mtop();
    instr_kind = K_PUSH; instr_imm = x0;
    low = 0; dn = 0;
    for (int c = 0; c < 3; c++) begin
      if (instr_ready === 1'b0) low++;
      if (done === 1'b1) dn++;
      @(posedge clk); #1;
    end
    n_checks++; if (low !== 3 || dn !== 0) begin n_errors++; $display("FAIL b2b_stall: got ready_low=%0d early_done=%0d expected 3 0", low, dn); end
    n_checks++; if (instr_ready !== 1'b1 || done !== 1'b1 || top !== exp_sum || depth !== SPW'(1)) begin n_errors++; $display("FAIL b2b_alu_retire: got ready=%b done=%b top=%0h depth=%0d expected 1 1 %0h 1", instr_ready, done, top, depth, exp_sum); end
    @(posedge clk); #1;
    model_step(K_PUSH, 3'd0, x0, 1'b0, el, ea, eb);
    instr_imm = x1;
    n_checks++; if (done !== 1'b1 || top !== x0 || depth !== SPW'(2)) begin n_errors++; $display("FAIL b2b_push0: got done=%b top=%0h depth=%0d expected 1 %0h 2", done, top, depth, x0); end
    @(posedge clk); #1;
    model_step(K_PUSH, 3'd0, x1, 1'b0, el, ea, eb);
    instr_valid = 1'b0;
    n_checks++; if (done !== 1'b1 || top !== x1 || depth !== SPW'(3)) begin n_errors++; $display("FAIL b2b_push1: got done=%b top=%0h depth=%0d expected 1 %0h 3", done, top, depth, x1); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || depth !== SPW'(3)) begin n_errors++; $display("FAIL b2b_idle: got done=%b depth=%0d expected 0 3", done, depth); end
  endtask

  task automatic test_reset_mid_alu();
    logic rdy; int lat, dn; logic [7:0] xa, xb; logic [2:0] xop;
    do_reset();
    drive_instr(K_POP, 3'd0, 8'h00, 1'b0, rdy, lat, xa, xb, xop);
    drive_instr(K_PUSH, 3'd0, 8'h01, 1'b0, rdy, lat, xa, xb, xop);
    drive_instr(K_PUSH, 3'd0, 8'h02, 1'b0, rdy, lat, xa, xb, xop);
    @(negedge clk);
    instr_kind = K_ALU; instr_op = OP_ADD; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (alu_a !== 8'h01 || alu_b !== 8'h02 || instr_ready !== 1'b0) begin n_errors++; $display("FAIL mid_exec: got a=%0h b=%0h ready=%b expected 01 02 0", alu_a, alu_b, instr_ready); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    n_checks++; if (depth !== '0 || top !== 8'h00 || done !== 1'b0 || instr_ready !== 1'b1) begin n_errors++; $display("FAIL mid_reset_state: got depth=%0d top=%0h done=%b ready=%b expected 0 0 0 1", depth, top, done, instr_ready); end
    n_checks++; if (err_underflow !== 1'b0 || err_overflow !== 1'b0) begin n_errors++; $display("FAIL mid_reset_err: got %b%b expected 00", err_overflow, err_underflow); end
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || depth !== '0) dn++;
    end
    n_checks++; if (dn !== 0) begin n_errors++; $display("FAIL mid_no_writeback: got %0d bad cycles expected 0", dn); end
    mstack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_random();
    logic rdy, clr; int lat, el; logic [7:0] xa, xb, ea, eb, im; logic [2:0] xop, o; logic [1:0] k;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      k = 2'($urandom_range(0, 3));
      o = 3'($urandom_range(0, 7));
      im = 8'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      drive_instr(k, o, im, clr, rdy, lat, xa, xb, xop);
      model_step(k, o, im, clr, el, ea, eb);
      n_checks++; if (rdy !== 1'b1) begin n_errors++; $display("FAIL rnd_ready[%0d]: got %b expected 1", i, rdy); end
      n_checks++; if (lat !== el) begin n_errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d kind=%0d", i, lat, el, k); end
      n_checks++; if (depth !== SPW'(mstack.size()) || top !== mtop()) begin n_errors++; $display("FAIL rnd_state[%0d]: got depth=%0d top=%0h expected %0d %0h", i, depth, top, mstack.size(), mtop()); end
      n_checks++; if (err_overflow !== m_ovf || err_underflow !== m_unf) begin n_errors++; $display("FAIL rnd_err[%0d]: got %b%b expected %b%b", i, err_overflow, err_underflow, m_ovf, m_unf); end
      if (el == 3) begin
        n_checks++; if (xa !== ea || xb !== eb || xop !== o) begin n_errors++; $display("FAIL rnd_exec_ops[%0d]: got a=%0h b=%0h op=%0d expected %0h %0h %0d", i, xa, xb, xop, ea, eb, o); end
      end
    end
  endtask

  initial begin
    m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_alu_directed();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid_alu();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
